// File: rtl/crca_arb_seq.sv
// crca_arb_seq: two-port round-robin arbiter that serialises a DATA_W-bit
// payload LSB-first into an external CRC engine, waits (bounded) for the
// engine's done strobe and returns the 16-bit result to the job's owner.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no job; arbitrate req0/req1, grant latches payload
// START | one-cycle engine start pulse, bit counter loaded
// SHIFT | DATA_W cycles of serial bits on eng_bit_o, LSB first
// WAIT  | wait for eng_done_i, give up after DONE_TMO cycles
// RESP  | result captured; owner's rvalid pulses on the next cycle
module crca_arb_seq #(
  parameter int DATA_W   = 32,
  parameter int DONE_TMO = 8
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [15:0]       crc_o,
  output logic              err_o,
  output logic              busy_o,
  output logic              eng_en_o,
  output logic              eng_bit_o,
  input  logic              eng_done_i,
  input  logic [15:0]       eng_crc_i
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int TMO_W = $clog2(DONE_TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SHIFT = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                owner_q, owner_d;
  logic                ptr_q, ptr_d;
  logic                ack0_d, ack1_d, rv0_d, rv1_d;
  logic                en_d, bit_d, busy_d, err_d;
  logic [15:0]         crc_d;
  logic                gnt1;
  logic                tmo_hit;

  // ptr_q holds the last granted port; on a tie the other port wins
  assign gnt1    = req1_i & (~req0_i | ~ptr_q);
  assign tmo_hit = (tmo_q == TMO_W'(DONE_TMO - 1));

  // State register
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req0_i || req1_i) state_d = S_START;
      S_START: state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == '0) state_d = S_WAIT;
      S_WAIT:  if (eng_done_i || tmo_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for datapath and registered outputs
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    crc_d   = crc_o;
    err_d   = err_o;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    en_d    = 1'b0;
    bit_d   = 1'b0;
    busy_d  = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          ack0_d  = ~gnt1;
          ack1_d  = gnt1;
          sr_d    = gnt1 ? data1_i : data0_i;
          owner_d = gnt1;
          ptr_d   = gnt1;
        end
      end
      S_START: begin
        // First bit is registered here so eng_bit_o lines up with SHIFT
        en_d  = 1'b1;
        cnt_d = CNT_W'(DATA_W - 1);
        bit_d = sr_q[0];
        sr_d  = {1'b0, sr_q[DATA_W-1:1]};
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          tmo_d = '0;
        end else begin
          bit_d = sr_q[0];
          sr_d  = {1'b0, sr_q[DATA_W-1:1]};
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (eng_done_i) begin
          crc_d = eng_crc_i;
          err_d = 1'b0;
        end else if (tmo_hit) begin
          crc_d = 16'h0000;
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RESP: begin
        rv0_d = ~owner_q;
        rv1_d = owner_q;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      owner_q   <= 1'b0;
      ptr_q     <= 1'b1;
      ack0_o    <= 1'b0;
      ack1_o    <= 1'b0;
      rvalid0_o <= 1'b0;
      rvalid1_o <= 1'b0;
      crc_o     <= 16'h0000;
      err_o     <= 1'b0;
      busy_o    <= 1'b0;
      eng_en_o  <= 1'b0;
      eng_bit_o <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      ack0_o    <= ack0_d;
      ack1_o    <= ack1_d;
      rvalid0_o <= rv0_d;
      rvalid1_o <= rv1_d;
      crc_o     <= crc_d;
      err_o     <= err_d;
      busy_o    <= busy_d;
      eng_en_o  <= en_d;
      eng_bit_o <= bit_d;
    end
  end

endmodule

// File: tb/tb_crca_arb_seq.sv
// Directed bench for crca_arb_seq with a scripted engine (done/crc driven
// inline at hand-computed cycles).
module tb_crca_arb_seq;

  localparam int DATA_W   = 32;
  localparam int DONE_TMO = 8;

  logic              clk_i = 1'b0;
  logic              resetn_i = 1'b1;
  logic              req0_i = 1'b0, req1_i = 1'b0;
  logic [DATA_W-1:0] data0_i = '0, data1_i = '0;
  logic              ack0_o, ack1_o, rvalid0_o, rvalid1_o;
  logic [15:0]       crc_o;
  logic              err_o, busy_o, eng_en_o, eng_bit_o;
  logic              eng_done_i = 1'b0;
  logic [15:0]       eng_crc_i = 16'h0000;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int waited;

  crca_arb_seq #(.DATA_W(DATA_W), .DONE_TMO(DONE_TMO)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .req0_i(req0_i), .req1_i(req1_i),
    .data0_i(data0_i), .data1_i(data1_i),
    .ack0_o(ack0_o), .ack1_o(ack1_o),
    .rvalid0_o(rvalid0_o), .rvalid1_o(rvalid1_o),
    .crc_o(crc_o), .err_o(err_o), .busy_o(busy_o),
    .eng_en_o(eng_en_o), .eng_bit_o(eng_bit_o),
    .eng_done_i(eng_done_i), .eng_crc_i(eng_crc_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one job from grant to result. k = WAIT cycle on which done arrives
  // (0 = never, expect timeout). pend_at = shift index at which req1 rises.
  task automatic do_job(input int port, input logic [31:0] data, input int k,
                        input bit spurious, input logic [15:0] crc,
                        input int pend_at, input bit hold, output int nwait);
    logic [31:0] bits;
    int t_ack, nw;
    nwait = 0;
    do begin
      tick();
      nwait++;
    end while (!(ack0_o || ack1_o) && nwait < 6);
    t_ack = cyc;
    check("ack_port", {30'd0, ack1_o, ack0_o}, (port == 1) ? 32'd2 : 32'd1);
    check("busy_at_ack", {31'd0, busy_o}, 32'd1);
    if (!hold) begin
      if (port == 0) begin req0_i = 1'b0; data0_i = ~data0_i; end
      else           begin req1_i = 1'b0; data1_i = ~data1_i; end
    end
    tick();
    check("eng_en_pulse", {31'd0, eng_en_o}, 32'd1);
    check("ack_one_cycle", {30'd0, ack1_o, ack0_o}, 32'd0);
    bits = '0;
    for (int i = 0; i < DATA_W; i++) begin
      bits[i] = eng_bit_o;
      if (i == 1) check("eng_en_one_cycle", {31'd0, eng_en_o}, 32'd0);
      eng_done_i = spurious && (i == 5);
      eng_crc_i  = (spurious && (i == 5)) ? 16'hDEAD : 16'h5555;
      if (pend_at == i) req1_i = 1'b1;
      tick();
    end
    eng_done_i = 1'b0;
    check("shift_bits", bits, data);
    check("bit_zero_after_shift", {31'd0, eng_bit_o}, 32'd0);
    check("no_ack_while_busy", {30'd0, ack1_o, ack0_o}, 32'd0);
    nw = (k == 0) ? DONE_TMO : k;
    for (int j = 1; j <= nw; j++) begin
      check("rvalid_early", {30'd0, rvalid1_o, rvalid0_o}, 32'd0);
      if (k != 0 && j == k) begin eng_done_i = 1'b1; eng_crc_i = crc; end
      tick();
      eng_done_i = 1'b0;
      eng_crc_i  = 16'h5555;
    end
    check("busy_in_resp", {31'd0, busy_o}, 32'd1);
    check("rvalid_in_resp", {30'd0, rvalid1_o, rvalid0_o}, 32'd0);
    tick();
    check("rvalid_port", {30'd0, rvalid1_o, rvalid0_o}, (port == 1) ? 32'd2 : 32'd1);
    check("crc", {16'd0, crc_o}, (k == 0) ? 32'd0 : {16'd0, crc});
    check("err", {31'd0, err_o}, (k == 0) ? 32'd1 : 32'd0);
    check("busy_fall", {31'd0, busy_o}, 32'd0);
    check("latency", cyc - t_ack, DATA_W + 2 + nw);
  endtask

  initial begin
    #3 resetn_i = 1'b0;
    #1;
    check("rst_outputs", {26'd0, ack0_o, ack1_o, rvalid0_o, rvalid1_o, busy_o, err_o}, 32'd0);
    check("rst_eng", {30'd0, eng_en_o, eng_bit_o}, 32'd0);
    check("rst_crc", {16'd0, crc_o}, 32'd0);
    tick(); tick();
    resetn_i = 1'b1;
    tick();

    // single job, done on first WAIT cycle: ack at cycle 1, rvalid at 36
    req0_i = 1'b1; data0_i = 32'h0000_0001;
    do_job(0, 32'h0000_0001, 1, 1'b0, 16'hBEEF, -1, 1'b0, waited);
    check("single_ack_latency", waited, 1);
    tick();
    check("rvalid_one_cycle", {30'd0, rvalid1_o, rvalid0_o}, 32'd0);

    // lone req1, spurious done in SHIFT must be ignored
    req1_i = 1'b1; data1_i = 32'hA5A5_0F0F;
    do_job(1, 32'hA5A5_0F0F, 2, 1'b1, 16'h1234, -1, 1'b0, waited);

    // timeout: engine never signals done
    req0_i = 1'b1; data0_i = 32'h8000_0003;
    do_job(0, 32'h8000_0003, 0, 1'b0, 16'h0000, -1, 1'b0, waited);

    // lone req0 while pointer favours port 1; req1 arrives during SHIFT
    data1_i = 32'h1357_9BDF;
    req0_i = 1'b1; data0_i = 32'h0000_FFFF;
    do_job(0, 32'h0000_FFFF, 1, 1'b0, 16'hCAFE, 3, 1'b0, waited);
    check("pending_no_ack_at_rvalid", {30'd0, ack1_o, ack0_o}, 32'd0);
    do_job(1, 32'h1357_9BDF, 4, 1'b0, 16'h0F0F, -1, 1'b0, waited);
    check("pending_ack_next_idle", waited, 1);

    // reset in the middle of SHIFT
    req0_i = 1'b1; data0_i = 32'hFFFF_FFFF;
    tick();
    check("rst_job_ack", {30'd0, ack1_o, ack0_o}, 32'd1);
    req0_i = 1'b0;
    repeat (8) tick();
    check("rst_job_shifting", {30'd0, busy_o, eng_bit_o}, 32'd3);
    resetn_i = 1'b0;
    #1;
    check("midjob_rst_outputs", {26'd0, ack0_o, ack1_o, rvalid0_o, rvalid1_o, busy_o, err_o}, 32'd0);
    check("midjob_rst_eng", {30'd0, eng_en_o, eng_bit_o}, 32'd0);
    tick(); tick();
    resetn_i = 1'b1;
    tick();
    check("no_rvalid_after_rst", {29'd0, busy_o, rvalid1_o, rvalid0_o}, 32'd0);

    req1_i = 1'b1; data1_i = 32'h2468_ACE0;
    do_job(1, 32'h2468_ACE0, 3, 1'b0, 16'h7777, -1, 1'b0, waited);
    check("post_rst_ack_latency", waited, 1);

    // tie: both held for three jobs, order 0,1,0
    req0_i = 1'b1; data0_i = 32'h1111_2222;
    req1_i = 1'b1; data1_i = 32'h3333_4444;
    do_job(0, 32'h1111_2222, 1, 1'b0, 16'h0001, -1, 1'b1, waited);
    do_job(1, 32'h3333_4444, 2, 1'b0, 16'h0002, -1, 1'b1, waited);
    check("tie_back_to_back", waited, 1);
    do_job(0, 32'h1111_2222, 1, 1'b0, 16'h0003, -1, 1'b0, waited);
    check("tie_third", waited, 1);
    req1_i = 1'b0;
    tick();
    check("idle_after_drop", {29'd0, busy_o, ack1_o, ack0_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
